// File: rtl/stopwatch_lap_core.sv
// Stopwatch counter with tick prescaler, pause, split/lap capture and a
// first-word-fall-through lap FIFO. Command pulses act only when exactly one is high.
module stopwatch_lap_core #(
  parameter int N        = 16,
  parameter int LAPS     = 4,
  parameter int PRESCALE = 1,
  parameter int WRAP     = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         split_i,
  input  logic         clear_i,
  input  logic         lap_rd_i,
  output logic [N-1:0] disp_value_o,
  output logic [N-1:0] count_value_o,
  output logic         running_o,
  output logic         frozen_o,
  output logic [N-1:0] lap_data_o,
  output logic         lap_valid_o,
  output logic         lap_full_o,
  output logic         lap_overrun_o,
  output logic         overflow_o
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int AW = (LAPS > 1) ? $clog2(LAPS) : 1;
  localparam int CW = $clog2(LAPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SPLIT, S_PAUSED} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  count_q, frozen_q;
  logic [PW-1:0] presc_q;
  logic [N-1:0]  mem_q [LAPS];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] fill_q;
  logic          running_q, frozen_flag_q, overrun_q, overflow_q;

  logic [3:0] cmds;
  logic       one_cmd, split_acc, clear_acc, counting_d, tick;
  logic       empty, full, pop, push;

  assign cmds    = {start_i, stop_i, split_i, clear_i};
  assign one_cmd = (cmds != 4'b0000) && ((cmds & (cmds - 4'd1)) == 4'b0000);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(LAPS - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    split_acc = 1'b0;
    clear_acc = 1'b0;
    if (one_cmd) begin
      unique case (state_q)
        S_IDLE: if (start_i) state_d = S_RUN;
        S_RUN: begin
          if (stop_i) state_d = S_PAUSED;
          if (split_i) begin
            state_d   = S_SPLIT;
            split_acc = 1'b1;
          end
        end
        S_SPLIT: begin
          if (start_i) state_d = S_RUN;
          if (stop_i)  state_d = S_PAUSED;
          split_acc = split_i;
        end
        S_PAUSED: begin
          if (start_i) state_d = S_RUN;
          if (clear_i) begin
            state_d   = S_IDLE;
            clear_acc = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counting follows the next state so a start/stop takes effect on the same edge.
  assign counting_d = (state_d == S_RUN) || (state_d == S_SPLIT);
  assign tick       = counting_d && (presc_q == PW'(PRESCALE - 1));

  assign empty = (fill_q == '0);
  assign full  = (fill_q == CW'(LAPS));
  assign pop   = lap_rd_i && !empty && !clear_acc;
  assign push  = split_acc && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      frozen_q      <= '0;
      presc_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      running_q     <= 1'b0;
      frozen_flag_q <= 1'b0;
      overrun_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      running_q     <= counting_d;
      frozen_flag_q <= (state_d == S_SPLIT);
      if (clear_acc) begin
        count_q    <= '0;
        frozen_q   <= '0;
        presc_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        fill_q     <= '0;
        overrun_q  <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        if (counting_d) presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (&count_q) begin
            overflow_q <= 1'b1;
            if (WRAP != 0) count_q <= '0;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        if (split_acc) frozen_q <= count_q;
        if (split_acc && full && !pop) overrun_q <= 1'b1;
        if (push) begin
          mem_q[wr_ptr_q] <= count_q;
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (push && !pop)      fill_q <= fill_q + 1'b1;
        else if (pop && !push) fill_q <= fill_q - 1'b1;
      end
    end
  end

  assign disp_value_o  = (state_q == S_SPLIT) ? frozen_q : count_q;
  assign count_value_o = count_q;
  assign running_o     = running_q;
  assign frozen_o      = frozen_flag_q;
  assign lap_data_o    = empty ? '0 : mem_q[rd_ptr_q];
  assign lap_valid_o   = !empty;
  assign lap_full_o    = full;
  assign lap_overrun_o = overrun_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Three stopwatch configurations driven in lockstep and compared against an
// abstract per-cycle model of the stopwatch rules.
module tb_stopwatch_lap_core;
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, stop = 1'b0, split = 1'b0, clear = 1'b0, lap_rd = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam int MD_IDLE = 0, MD_RUN = 1, MD_SPLIT = 2, MD_PAUSED = 3;

  // configurations: u0 N=8 LAPS=2 P=1 wrap; u1 N=4 LAPS=4 P=3 saturate; u2 N=4 LAPS=1 P=1 wrap
  int p_n[3] = '{8, 4, 4};
  int p_l[3] = '{2, 4, 1};
  int p_p[3] = '{1, 3, 1};
  int p_w[3] = '{1, 0, 1};

  int m_mode[3], m_cnt[3], m_presc[3], m_frz[3], m_len[3], m_ovr[3], m_ovf[3];
  int m_q[3][8];

  logic [7:0] o_disp[3], o_cnt[3], o_data[3];
  logic       o_run[3], o_frz[3], o_valid[3], o_full[3], o_ovr[3], o_ovf[3];

  logic [7:0] d0_disp, d0_cnt, d0_data;
  logic [3:0] d1_disp, d1_cnt, d1_data, d2_disp, d2_cnt, d2_data;

  stopwatch_lap_core #(.N(8), .LAPS(2), .PRESCALE(1), .WRAP(1)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .split_i(split),
    .clear_i(clear), .lap_rd_i(lap_rd), .disp_value_o(d0_disp), .count_value_o(d0_cnt),
    .running_o(o_run[0]), .frozen_o(o_frz[0]), .lap_data_o(d0_data),
    .lap_valid_o(o_valid[0]), .lap_full_o(o_full[0]), .lap_overrun_o(o_ovr[0]),
    .overflow_o(o_ovf[0]));
  stopwatch_lap_core #(.N(4), .LAPS(4), .PRESCALE(3), .WRAP(0)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .split_i(split),
    .clear_i(clear), .lap_rd_i(lap_rd), .disp_value_o(d1_disp), .count_value_o(d1_cnt),
    .running_o(o_run[1]), .frozen_o(o_frz[1]), .lap_data_o(d1_data),
    .lap_valid_o(o_valid[1]), .lap_full_o(o_full[1]), .lap_overrun_o(o_ovr[1]),
    .overflow_o(o_ovf[1]));
  stopwatch_lap_core #(.N(4), .LAPS(1), .PRESCALE(1), .WRAP(1)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .split_i(split),
    .clear_i(clear), .lap_rd_i(lap_rd), .disp_value_o(d2_disp), .count_value_o(d2_cnt),
    .running_o(o_run[2]), .frozen_o(o_frz[2]), .lap_data_o(d2_data),
    .lap_valid_o(o_valid[2]), .lap_full_o(o_full[2]), .lap_overrun_o(o_ovr[2]),
    .overflow_o(o_ovf[2]));

  assign o_disp[0] = d0_disp;           assign o_cnt[0] = d0_cnt;           assign o_data[0] = d0_data;
  assign o_disp[1] = {4'b0, d1_disp};   assign o_cnt[1] = {4'b0, d1_cnt};   assign o_data[1] = {4'b0, d1_data};
  assign o_disp[2] = {4'b0, d2_disp};   assign o_cnt[2] = {4'b0, d2_cnt};   assign o_data[2] = {4'b0, d2_data};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    int ncmd, nm, fs, old;
    bit do_clear, do_split, pop;
    if (rst) begin
      m_mode[i] = MD_IDLE; m_cnt[i] = 0; m_presc[i] = 0; m_frz[i] = 0;
      m_len[i] = 0; m_ovr[i] = 0; m_ovf[i] = 0;
      return;
    end
    ncmd = int'(start) + int'(stop) + int'(split) + int'(clear);
    nm = m_mode[i]; do_clear = 0; do_split = 0;
    if (ncmd == 1) begin
      if (m_mode[i] == MD_IDLE && start) nm = MD_RUN;
      if (m_mode[i] == MD_RUN && stop) nm = MD_PAUSED;
      if (m_mode[i] == MD_RUN && split) begin nm = MD_SPLIT; do_split = 1; end
      if (m_mode[i] == MD_SPLIT && start) nm = MD_RUN;
      if (m_mode[i] == MD_SPLIT && stop) nm = MD_PAUSED;
      if (m_mode[i] == MD_SPLIT && split) do_split = 1;
      if (m_mode[i] == MD_PAUSED && start) nm = MD_RUN;
      if (m_mode[i] == MD_PAUSED && clear) begin nm = MD_IDLE; do_clear = 1; end
    end
    fs  = (1 << p_n[i]) - 1;
    old = m_cnt[i];
    pop = lap_rd && (m_len[i] > 0) && !do_clear;
    if (do_clear) begin
      m_cnt[i] = 0; m_presc[i] = 0; m_frz[i] = 0; m_len[i] = 0; m_ovr[i] = 0; m_ovf[i] = 0;
    end else begin
      if (nm == MD_RUN || nm == MD_SPLIT) begin
        if (m_presc[i] == p_p[i] - 1) begin
          if (m_cnt[i] == fs) begin
            m_ovf[i] = 1;
            m_cnt[i] = (p_w[i] != 0) ? 0 : fs;
          end else m_cnt[i] = m_cnt[i] + 1;
        end
        m_presc[i] = (m_presc[i] + 1) % p_p[i];
      end
      if (pop) begin
        for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
        m_len[i] = m_len[i] - 1;
      end
      if (do_split) begin
        m_frz[i] = old;
        if (m_len[i] < p_l[i]) begin
          m_q[i][m_len[i]] = old;
          m_len[i] = m_len[i] + 1;
        end else m_ovr[i] = 1;
      end
    end
    m_mode[i] = nm;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.disp", i), 32'(o_disp[i]),
          (m_mode[i] == MD_SPLIT) ? m_frz[i] : m_cnt[i]);
      chk($sformatf("u%0d.count", i), 32'(o_cnt[i]), m_cnt[i]);
      chk($sformatf("u%0d.running", i), 32'(o_run[i]),
          (m_mode[i] == MD_RUN || m_mode[i] == MD_SPLIT) ? 1 : 0);
      chk($sformatf("u%0d.frozen", i), 32'(o_frz[i]), (m_mode[i] == MD_SPLIT) ? 1 : 0);
      chk($sformatf("u%0d.lap_valid", i), 32'(o_valid[i]), (m_len[i] > 0) ? 1 : 0);
      chk($sformatf("u%0d.lap_full", i), 32'(o_full[i]), (m_len[i] == p_l[i]) ? 1 : 0);
      if (m_len[i] > 0) chk($sformatf("u%0d.lap_data", i), 32'(o_data[i]), m_q[i][0]);
      chk($sformatf("u%0d.overrun", i), 32'(o_ovr[i]), m_ovr[i]);
      chk($sformatf("u%0d.overflow", i), 32'(o_ovf[i]), m_ovf[i]);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit p, input bit sp,
                     input bit c, input bit rd);
    rst = r; start = s; stop = p; split = sp; clear = c; lap_rd = rd;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1 check_all();
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int x;
    bit r, s, p, sp, c, rd;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 1);
    chk("reset.count", 32'(o_cnt[0]), 0);
    chk("reset.running", 32'(o_run[0]), 0);
    chk("reset.lap_valid", 32'(o_valid[0]), 0);

    // basic run/pause; prescaler keeps its phase across the pause
    cyc(0, 1, 0, 0, 0, 0);
    nops(9);
    cyc(0, 0, 1, 0, 0, 0);
    chk("run10.count", 32'(o_cnt[0]), 10);
    chk("run10.running", 32'(o_run[0]), 0);
    chk("presc3.count", 32'(o_cnt[1]), 3);
    nops(5);
    chk("paused.hold", 32'(o_cnt[0]), 10);
    cyc(0, 1, 0, 0, 0, 0);
    nops(2);
    chk("presc3.resume", 32'(o_cnt[1]), 4);

    // ignored commands while running, then pause + clear
    cyc(0, 1, 1, 0, 0, 0);
    chk("illegal.running", 32'(o_run[0]), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("clear_in_run.count", 32'(o_cnt[0]), 15);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("clear.count", 32'(o_cnt[0]), 0);
    chk("clear.running", 32'(o_run[0]), 0);
    chk("clear.disp", 32'(o_disp[0]), 0);
    chk("clear.lap_valid", 32'(o_valid[0]), 0);

    // split capture, FIFO fill and overrun on the 2-deep instance
    cyc(0, 1, 0, 0, 0, 0);
    nops(4);
    cyc(0, 0, 0, 1, 0, 0);
    chk("split5.frozen", 32'(o_frz[0]), 1);
    chk("split5.disp", 32'(o_disp[0]), 5);
    nops(1);
    chk("split5.disp_held", 32'(o_disp[0]), 5);
    chk("split5.count_live", 32'(o_cnt[0]), 7);
    nops(2);
    cyc(0, 0, 0, 1, 0, 0);
    nops(2);
    cyc(0, 0, 0, 1, 0, 0);
    chk("split12.overrun", 32'(o_ovr[0]), 1);
    chk("split12.disp", 32'(o_disp[0]), 12);
    chk("split12.head", 32'(o_data[0]), 5);
    chk("split12.full", 32'(o_full[0]), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("pop1.head", 32'(o_data[0]), 9);
    cyc(0, 0, 0, 0, 0, 1);
    chk("pop2.valid", 32'(o_valid[0]), 0);

    // reset while split with two laps stored
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("pre_rst.full", 32'(o_full[0]), 1);
    cyc(1, 0, 0, 1, 0, 1);
    chk("rst.running", 32'(o_run[0]), 0);
    chk("rst.count", 32'(o_cnt[0]), 0);
    chk("rst.lap_valid", 32'(o_valid[0]), 0);
    chk("rst.frozen", 32'(o_frz[0]), 0);
    chk("rst.overrun", 32'(o_ovr[0]), 0);
    chk("rst.overflow", 32'(o_ovf[0]), 0);

    // wrap on u2 after 16 ticks, saturation on u1 after 20 ticks
    cyc(0, 1, 0, 0, 0, 0);
    nops(15);
    chk("wrap.count", 32'(o_cnt[2]), 0);
    chk("wrap.overflow", 32'(o_ovf[2]), 1);
    nops(44);
    chk("sat.count", 32'(o_cnt[1]), 15);
    chk("sat.overflow", 32'(o_ovf[1]), 1);
    chk("sat.running", 32'(o_run[1]), 1);

    // randomized command traffic
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 299) == 0);
      s = 0; p = 0; sp = 0; c = 0;
      x = $urandom_range(0, 99);
      if (x >= 55 && x < 95) begin
        case ($urandom_range(0, 3))
          0: s = 1;
          1: p = 1;
          2: sp = 1;
          default: c = 1;
        endcase
      end else if (x >= 95) begin
        {s, p, sp, c} = 4'($urandom_range(0, 15));
      end
      rd = ($urandom_range(0, 3) == 0);
      cyc(r, s, p, sp, c, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
